// File: rtl/multi_ch_clk_div_if.sv
// Divisor write bus for multi_ch_clk_div: the controller drives a channel/divisor
// write and observes the one-cycle rejection pulse.
interface multi_ch_clk_div_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 21
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             wr_en;
   logic [CH_W-1:0]  wr_ch;
   logic [CNT_W-1:0] wr_div;
   logic             wr_err;

   modport master (output wr_en, wr_ch, wr_div, input wr_err);
   modport slave  (input wr_en, wr_ch, wr_div, output wr_err);
endinterface

// File: rtl/multi_ch_clk_div.sv
// NUM_CH independent programmable clock dividers (tick strobe + square wave each).
// Optional MULTI_CH_CLK_DIV_PHASE_SYNC_EN adds sync_in to phase-align all channels.
module multi_ch_clk_div #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 21,
   parameter int DEF_DIV = 2500
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
`ifdef MULTI_CH_CLK_DIV_PHASE_SYNC_EN
   input  logic              sync_in,
`endif
   multi_ch_clk_div_if.slave wr,
   output logic [NUM_CH-1:0] pend,
   output logic [NUM_CH-1:0] tick_out,
   output logic [NUM_CH-1:0] sq_out
);
   localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CH_W:0]    NUM_CH_L  = (CH_W + 1)'(NUM_CH);
   localparam logic [CNT_W-1:0] DEF_DIV_L = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   logic wr_ok;
   logic sync_now;
   logic wr_err_reg;

`ifdef MULTI_CH_CLK_DIV_PHASE_SYNC_EN
   assign sync_now = sync_in;
`else
   assign sync_now = 1'b0;
`endif

   // A write is valid only for an existing channel and a non-zero divisor.
   assign wr_ok = wr.wr_en && ({1'b0, wr.wr_ch} < NUM_CH_L) && (wr.wr_div != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_err_reg <= 1'b0;
      end else begin
         wr_err_reg <= wr.wr_en && !wr_ok;
      end
   end

   assign wr.wr_err = wr_err_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] cnt_reg,  cnt_next;
         logic [CNT_W-1:0] div_reg,  div_next;
         logic [CNT_W-1:0] pdiv_reg, pdiv_next;
         logic             pend_reg, pend_next;
         logic             tick_reg, tick_next;
         logic             sq_reg,   sq_next;
         logic             term;
         logic             half;
         logic             hit;

         assign term = (cnt_reg == div_reg - ONE);
         // For div_reg==1 this wraps to all-ones and never matches, so sq stays high.
         assign half = (cnt_reg == (div_reg >> 1) - ONE);
         assign hit  = wr_ok && (wr.wr_ch == CH_W'(gi));

         always_comb begin
            cnt_next  = cnt_reg;
            div_next  = div_reg;
            pdiv_next = pdiv_reg;
            pend_next = pend_reg;
            tick_next = 1'b0;
            sq_next   = sq_reg;
            if (sync_now) begin
               cnt_next = '0;
               sq_next  = 1'b0;
               if (pend_reg) begin
                  div_next  = pdiv_reg;
                  pend_next = 1'b0;
               end
            end else if (en) begin
               if (term) begin
                  cnt_next  = '0;
                  tick_next = 1'b1;
                  sq_next   = 1'b1;
                  if (pend_reg) begin
                     div_next  = pdiv_reg;
                     pend_next = 1'b0;
                  end
               end else begin
                  cnt_next = cnt_reg + ONE;
                  if (half) begin
                     sq_next = 1'b0;
                  end
               end
            end
            // The swap above used the old pending value; a same-cycle write queues for next boundary.
            if (hit) begin
               pdiv_next = wr.wr_div;
               pend_next = 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_reg  <= '0;
               div_reg  <= DEF_DIV_L;
               pdiv_reg <= DEF_DIV_L;
               pend_reg <= 1'b0;
               tick_reg <= 1'b0;
               sq_reg   <= 1'b0;
            end else begin
               cnt_reg  <= cnt_next;
               div_reg  <= div_next;
               pdiv_reg <= pdiv_next;
               pend_reg <= pend_next;
               tick_reg <= tick_next;
               sq_reg   <= sq_next;
            end
         end

         assign pend[gi]     = pend_reg;
         assign tick_out[gi] = tick_reg;
         assign sq_out[gi]   = sq_reg;
      end
   endgenerate
endmodule

// File: tb/tb_multi_ch_clk_div.sv
// Bench for multi_ch_clk_div: directed timeline with literal expectations plus
// randomized traffic checked every cycle against a behavioural channel model.
module tb_multi_ch_clk_div;
   localparam int NUM_CH  = 3;
   localparam int CNT_W   = 8;
   localparam int DEF_DIV = 4;
   localparam int CH_W    = 2;

   logic              clk;
   logic              rst;
   logic              en;
   logic              sync_s;
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] tick_out;
   logic [NUM_CH-1:0] sq_out;

   int total = 0;
   int bad   = 0;

   multi_ch_clk_div_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   multi_ch_clk_div #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
`ifdef MULTI_CH_CLK_DIV_PHASE_SYNC_EN
      .sync_in  (sync_s),
`endif
      .wr       (bus),
      .pend     (pend),
      .tick_out (tick_out),
      .sq_out   (sq_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: position within the current period, active/pending divisor.
   int m_d[NUM_CH];
   int m_p[NUM_CH];
   int m_pend[NUM_CH];
   int m_c[NUM_CH];
   int m_seen[NUM_CH];
   int m_tick[NUM_CH];
   int m_err;

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_d[i] = DEF_DIV; m_p[i] = 0; m_pend[i] = 0;
         m_c[i] = 0; m_seen[i] = 0; m_tick[i] = 0;
      end
      m_err = 0;
   endtask

   task automatic model_step();
      int  ch;
      int  dv;
      bit  ok;
      bit  s;
      ch = int'(bus.wr_ch);
      dv = int'(bus.wr_div);
      ok = bus.wr_en && (ch < NUM_CH) && (dv != 0);
      s  = 1'b0;
`ifdef MULTI_CH_CLK_DIV_PHASE_SYNC_EN
      s  = sync_s;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         m_tick[i] = 0;
         if (s) begin
            m_c[i] = 0; m_seen[i] = 0;
            if (m_pend[i] != 0) begin m_d[i] = m_p[i]; m_pend[i] = 0; end
         end else if (en) begin
            if (m_c[i] + 1 == m_d[i]) begin
               m_c[i] = 0; m_tick[i] = 1; m_seen[i] = 1;
               if (m_pend[i] != 0) begin m_d[i] = m_p[i]; m_pend[i] = 0; end
            end else begin
               m_c[i] = m_c[i] + 1;
            end
         end
         if (ok && ch == i) begin m_p[i] = dv; m_pend[i] = 1; end
      end
      m_err = (bus.wr_en && !ok) ? 1 : 0;
   endtask

   // Every-cycle comparison against the model, 1 time unit after the rising edge.
   initial begin
      logic [NUM_CH-1:0] e_tick, e_sq, e_pend;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) model_reset();
         else      model_step();
         for (int i = 0; i < NUM_CH; i++) begin
            e_tick[i] = (m_tick[i] != 0);
            e_pend[i] = (m_pend[i] != 0);
            // High for floor(D/2) cycles after each terminal count; D=1 holds high.
            e_sq[i]   = (m_seen[i] != 0) && (m_d[i] == 1 || m_c[i] < m_d[i] / 2);
         end
         chk("model_tick", 32'(tick_out), 32'(e_tick));
         chk("model_sq",   32'(sq_out),   32'(e_sq));
         chk("model_pend", 32'(pend),     32'(e_pend));
         chk("model_err",  32'(bus.wr_err), 32'(m_err));
      end
   end

   task automatic step(input bit e, input bit w, input int ch, input int dv, input bit s);
      @(negedge clk);
      en         = e;
      bus.wr_en  = w;
      bus.wr_ch  = CH_W'(ch);
      bus.wr_div = CNT_W'(dv);
      sync_s     = s;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; en = 1'b0; bus.wr_en = 1'b0; sync_s = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      bit e, w, s;
      int ch, dv;
      rst = 1'b1; en = 1'b0; sync_s = 1'b0;
      bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_div = '0;
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_tick", 32'(tick_out), 0);
      chk("reset_sq",   32'(sq_out),   0);
      chk("reset_pend", 32'(pend),     0);
      chk("reset_err",  32'(bus.wr_err), 0);

      // Default divisor 4: ticks at 4, 8, 12; square wave 2 high / 2 low.
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         step(1, 0, 0, 0, 0);
         chk("t1_tick", 32'(tick_out), (k % 4 == 0) ? 32'h7 : 32'h0);
         chk("t1_sq",   32'(sq_out), (k >= 4 && (k % 4 == 0 || k % 4 == 1)) ? 32'h7 : 32'h0);
      end

      // Rate change, rejected writes, D=1, pause, write on a terminal cycle.
      do_reset();
      for (int k = 1; k <= 45; k++) begin
         e = 1; w = 0; ch = 0; dv = 0;
         case (k)
            2:  begin w = 1; ch = 0; dv = 6; end
            17: begin w = 1; ch = 1; dv = 0; end
            18: begin w = 1; ch = 3; dv = 5; end
            20: begin w = 1; ch = 1; dv = 1; end
            40: begin w = 1; ch = 0; dv = 3; end
            default: ;
         endcase
         if (k >= 31 && k <= 35) e = 0;
         step(e, w, ch, dv, 0);
         case (k)
            2:  chk("t2_pend_set", 32'(pend), 32'h1);
            4:  begin chk("t2_pend_clr", 32'(pend), 0); chk("t2_tick4", 32'(tick_out), 32'h7); end
            8:  chk("t2_tick8",  32'(tick_out), 32'h6);
            10: chk("t2_tick10", 32'(tick_out), 32'h1);
            16: chk("t2_tick16", 32'(tick_out), 32'h7);
            17: chk("t3_err_div0", 32'(bus.wr_err), 1);
            18: chk("t3_err_ch",   32'(bus.wr_err), 1);
            19: begin chk("t3_err_gone", 32'(bus.wr_err), 0); chk("t3_pend", 32'(pend), 0); end
            21: chk("t5_old_div", 32'(tick_out[1]), 0);
            24: begin chk("t5_tick24", 32'(tick_out[1]), 1); chk("t5_pend24", 32'(pend), 0); end
            25, 26, 27: begin
               chk("t3_d1_tick", 32'(tick_out[1]), 1);
               chk("t3_d1_sq",   32'(sq_out[1]),   1);
            end
            33: begin chk("t4_tick_off", 32'(tick_out), 0); chk("t4_sq_frz", 32'(sq_out[2]), 0); end
            36: chk("t4_ch2_wait", 32'(tick_out[2]), 0);
            37: chk("t4_ch2_tick", 32'(tick_out[2]), 1);
            38: chk("t4_ch0_wait", 32'(tick_out[0]), 0);
            39: chk("t4_ch0_tick", 32'(tick_out[0]), 1);
            40: chk("t5_pend40", 32'(pend), 32'h1);
            default: ;
         endcase
      end
      // Asynchronous reset in mid-period with a pending write.
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t5_rst_pend", 32'(pend),     0);
      chk("t5_rst_tick", 32'(tick_out), 0);
      chk("t5_rst_sq",   32'(sq_out),   0);
      chk("t5_rst_err",  32'(bus.wr_err), 0);
      @(negedge clk);
      rst = 1'b1;

`ifdef MULTI_CH_CLK_DIV_PHASE_SYNC_EN
      do_reset();
      for (int k = 1; k <= 24; k++) begin
         step(1, k == 1, 1, 8, k == 7);
         case (k)
            7:  begin chk("t6_sq", 32'(sq_out), 0); chk("t6_tick", 32'(tick_out), 0); end
            11: chk("t6_tick11", 32'(tick_out[1:0]), 32'h1);
            15: chk("t6_tick15", 32'(tick_out[1:0]), 32'h3);
            19: chk("t6_tick19", 32'(tick_out[1:0]), 32'h1);
            23: chk("t6_tick23", 32'(tick_out[1:0]), 32'h3);
            default: ;
         endcase
      end
`endif

      // Randomized traffic; the model process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end else begin
            e  = ($urandom_range(0, 9) != 0);
            w  = ($urandom_range(0, 2) == 0);
            ch = int'($urandom_range(0, 3));
            dv = int'($urandom_range(0, 9));
            s  = ($urandom_range(0, 39) == 0);
            step(e, w, ch, dv, s);
         end
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multi_ch_clk_div.md
Name: multi_ch_clk_div

Overview:
- Parametrised successor to the single fixed-rate divider.
- Generates NUM_CH independent slow-rate outputs from the system clock.
- Each channel provides:
  - a square wave, for LED blink and 7-seg digit select;
  - a one-cycle tick strobe, for FSM enables.
- Per-channel divisors are programmable at run time and change glitch-free on period boundaries.
- Sits between the board clock and the display and scan logic.

Parameters:
- NUM_CH, 4: number of independent channels (1..16).
- CNT_W, 21: divisor and counter width in bits.
- DEF_DIV, 2500: reset divisor for every channel (100 kHz / 40 Hz); must be 1..2^CNT_W-1.
- CH_W, derived as max(1, clog2(NUM_CH)): width of wr_ch. This is a localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global count enable.
- wr_en  in  1  divisor write strobe.
- wr_ch  in  CH_W  target channel.
- wr_div  in  CNT_W  new divisor D (output period = D clk cycles).
- wr_err  out  1  one-cycle pulse when a write is rejected.
- pend  out  NUM_CH  per-channel "new divisor waiting" flag.
- tick_out  out  NUM_CH  per-channel one-cycle strobe, once per period.
- sq_out  out  NUM_CH  per-channel square wave.

Behaviour:
- Reset (rst=0, async): every channel's active divisor D=DEF_DIV and cnt=0. All of tick_out, sq_out, pend and wr_err go to 0.
- Per-channel state:
  - cnt: counts 0..D-1.
  - D: active divisor.
  - P: pending divisor.
  - pend: pending flag.
- Counting with en=1:
  - Terminal count is cnt==D-1. On terminal: cnt<=0 and tick_out<=1 for the next cycle. If pend=1, also D<=P and pend<=0.
  - Otherwise cnt<=cnt+1 and tick_out<=0.
- Square wave:
  - Registered.
  - Set on terminal count.
  - Cleared when cnt==(D>>1)-1, evaluated with the currently active D.
  - Result: sq_out is high floor(D/2) cycles and low ceil(D/2) cycles per period. Exact 50% duty for even D.
- D=1: tick_out held high every cycle; sq_out held 1, since the clear condition never matches.
- Latency:
  - tick_out rises exactly 1 cycle after the terminal-count cycle.
  - The first tick after reset with en=1 appears at cycle D.
- en=0:
  - cnt, D and sq_out frozen; tick_out forced 0.
  - Writes are still accepted.
- Write handling, sampled each cycle wr_en=1:
  - Accept when wr_ch<NUM_CH and wr_div!=0: P<=wr_div, pend<=1.
  - Otherwise reject: no state change, wr_err<=1 for one cycle.
  - A repeated write while pend=1 overwrites P; the last one wins.
- Write on the same cycle as terminal count:
  - The swap uses the P/pend registered before this cycle.
  - The new write then sets P and pend=1 and takes effect at the following terminal count.
  - If no prior pending value existed, D is unchanged this boundary.
- Rate change: the old divisor always completes its full current period; no truncated or stretched pulse.
- Reset mid-period: immediate return to reset values; pending writes are discarded.
- Channels are fully independent; only en and the write bus are shared.

Optional Feature:
- Macro: MULTI_CH_CLK_DIV_PHASE_SYNC_EN.
- Defined: adds input port sync_in (1 bit, placed after en). On a cycle with sync_in=1, every channel does all of the following:
  - cnt<=0;
  - if pend=1, D<=P and pend<=0 immediately;
  - sq_out<=0;
  - tick_out<=0.
- sync_in has priority over en and over terminal count. A write in the same cycle lands in P with pend=1, after the sync swap.
- Purpose: phase-align all channels for multiplexed 7-seg scan.
- Undefined: the port is absent; behaviour is exactly as above.

Test Plan:
1. NUM_CH=2, DEF_DIV=4. Release reset, en=1 -> tick_out[0] and tick_out[1] pulse at cycles 4, 8, 12; sq_out high 2 cycles, low 2 cycles.
2. Write ch0 div=6 at cycle 2 -> pend[0]=1; period stays 4 until the cnt==3 boundary, then ticks every 6 cycles; pend[0] clears at that boundary; ch1 unaffected.
3. Writes wr_div=0 and wr_ch=3 (NUM_CH=2) -> wr_err pulses one cycle each; pend and D unchanged. Write div=1 -> after the boundary tick_out is continuously 1 and sq_out is 1.
4. en=0 for 5 cycles mid-period at cnt=2 -> tick_out=0, sq_out frozen; after en=1 the next tick arrives exactly 2 cycles later.
5. Write on a terminal-count cycle with no prior pend -> D is unchanged for one more period, then switches. Assert rst=0 mid-period with pend=1 -> all outputs 0 and pend cleared asynchronously.
6. (PHASE_SYNC_EN) ch0 D=4, ch1 D=8, pulse sync_in at an arbitrary cycle -> both cnt=0 and both sq_out=0; ticks coincide 4 and 8 cycles later, then every 8 cycles.
